// File: rtl/coasia_approval_if.sv
// ---------------------------------------------------------------------------
// coasia_approval_if
// Application bus between an application source (master) and the approval
// engine (slave).
//   mems      master->slave  applicant family size, 0 = no application
//   lang_cer  master->slave  language certificate level 0..3
//   kore_sub  master->slave  Korean-subject credit present
//   approval  slave->master  one-cycle decision code
//                            00 none, 01 approved, 10 rejected, 11 deferred
// ---------------------------------------------------------------------------
interface coasia_approval_if;
   logic [2:0] mems;
   logic [1:0] lang_cer;
   logic       kore_sub;
   logic [1:0] approval;

   modport master (
      output mems,
      output lang_cer,
      output kore_sub,
      input  approval
   );

   modport slave (
      input  mems,
      input  lang_cer,
      input  kore_sub,
      output approval
   );
endinterface

// File: rtl/coasia_approval_engine.sv
// ---------------------------------------------------------------------------
// coasia_approval_engine
// Visa-application decision engine. Samples an application from the bus,
// scores it, applies eligibility rules and a per-window approval quota, and
// returns a one-cycle decision code two edges after the sample.
//
// Ports:
//   i_clk       single clock, all logic on posedge
//   i_rst       synchronous reset, active-high
//   bus         coasia_approval_if slave (mems/lang_cer/kore_sub in,
//               approval out)
//   o_appr_cnt  approvals issued, saturates at 255
//   o_rej_cnt   rejections issued, saturates at 255
//   o_drop_cnt  applications ignored while busy, saturates at 255
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting; latches an application when mems != 0
//   EVAL   | registers score and large-family flag
//   DECIDE | loads approval code, updates counters and quota
// ---------------------------------------------------------------------------
module coasia_approval_engine #(
   parameter int QUOTA_MAX  = 4,
   parameter int WINDOW_CYC = 16,
   parameter int MIN_SCORE  = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   coasia_approval_if.slave      bus,
   output logic [7:0]            o_appr_cnt,
   output logic [7:0]            o_rej_cnt,
   output logic [7:0]            o_drop_cnt
);

   localparam int WIN_W = (WINDOW_CYC > 2) ? $clog2(WINDOW_CYC) : 1;

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_APPR  = 2'b01;
   localparam logic [1:0] CODE_REJ   = 2'b10;
   localparam logic [1:0] CODE_DEFER = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      DECIDE = 2'd2
   } state_t;

   state_t           r_state;
   logic [2:0]       r_mems;
   logic [1:0]       r_lang_cer;
   logic             r_kore_sub;
   logic [2:0]       r_score;
   logic             r_large;
   logic [1:0]       r_approval;
   logic [7:0]       r_appr_cnt;
   logic [7:0]       r_rej_cnt;
   logic [7:0]       r_drop_cnt;
   logic [WIN_W-1:0] r_win_cnt;
   logic [3:0]       r_quota_used;

   logic             w_present;
   logic             w_wrap;
   logic [1:0]       w_decision;
   logic             w_grant;

   assign w_present = (bus.mems != 3'd0);
   assign w_wrap    = (r_win_cnt == WIN_W'(WINDOW_CYC - 1));

   // Priority: large family without credit, then low score, then quota.
   always_comb begin
      w_decision = CODE_APPR;
      if (r_large && !r_kore_sub) begin
         w_decision = CODE_REJ;
      end else if (r_score < 3'(MIN_SCORE)) begin
         w_decision = CODE_REJ;
      end else if (r_quota_used == 4'(QUOTA_MAX)) begin
         w_decision = CODE_DEFER;
      end
   end

   assign w_grant = (r_state == DECIDE) && (w_decision == CODE_APPR);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_mems       <= 3'd0;
         r_lang_cer   <= 2'd0;
         r_kore_sub   <= 1'b0;
         r_score      <= 3'd0;
         r_large      <= 1'b0;
         r_approval   <= CODE_NONE;
         r_appr_cnt   <= 8'd0;
         r_rej_cnt    <= 8'd0;
         r_drop_cnt   <= 8'd0;
         r_win_cnt    <= '0;
         r_quota_used <= 4'd0;
      end else begin
         r_approval <= CODE_NONE;

         if (w_wrap) begin
            r_win_cnt <= '0;
         end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
         end

         // A grant on the wrap edge belongs to the new window.
         if (w_wrap) begin
            r_quota_used <= w_grant ? 4'd1 : 4'd0;
         end else if (w_grant) begin
            r_quota_used <= r_quota_used + 4'd1;
         end

         if ((r_state != IDLE) && w_present && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
         end

         case (r_state)
            IDLE: begin
               if (w_present) begin
                  r_mems     <= bus.mems;
                  r_lang_cer <= bus.lang_cer;
                  r_kore_sub <= bus.kore_sub;
                  r_state    <= EVAL;
               end
            end
            EVAL: begin
               r_score <= {1'b0, r_lang_cer} + {1'b0, r_kore_sub, 1'b0};
               r_large <= (r_mems >= 3'd5);
               r_state <= DECIDE;
            end
            DECIDE: begin
               r_approval <= w_decision;
               if ((w_decision == CODE_APPR) && (r_appr_cnt != 8'hFF)) begin
                  r_appr_cnt <= r_appr_cnt + 8'd1;
               end
               if ((w_decision == CODE_REJ) && (r_rej_cnt != 8'hFF)) begin
                  r_rej_cnt <= r_rej_cnt + 8'd1;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.approval = r_approval;
   assign o_appr_cnt   = r_appr_cnt;
   assign o_rej_cnt    = r_rej_cnt;
   assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: doc/coasia_approval_engine.md
Name: coasia_approval_engine

Overview:
- Visa-application decision engine; the DUT on the slave side of the coasia application bus.
- It samples each application (mems, lang_cer, kore_sub), scores it and checks eligibility rules.
- It applies a per-window approval quota and drives a one-cycle approval code back to the master.
- It also keeps saturating status counters for approvals, rejections and dropped applications.

Parameters:
- QUOTA_MAX, 4: max approvals (code 01) granted per quota window; range 1..15.
- WINDOW_CYC, 16: quota window length in clk cycles; range 2..256.
- MIN_SCORE, 3: minimum score for approval; range 0..5.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- mems  input  3  applicant family size; 0 = no application this cycle.
- lang_cer  input  2  language certificate level 0..3.
- kore_sub  input  1  Korean-subject credit present.
- approval  output  2  decision code: 00 none, 01 approved, 10 rejected, 11 deferred (quota exhausted).
- appr_cnt  output  8  approvals issued; saturates at 255.
- rej_cnt  output  8  rejections issued; saturates at 255.
- drop_cnt  output  8  applications ignored while busy; saturates at 255.

Behaviour:
- Interface: one clock domain (clk); reset rst is synchronous and active-high.
- Reset state: FSM = IDLE, approval = 00, all counters = 0, win_cnt = 0, quota_used = 0.
  - Reset overrides every other event at the same edge.
  - Reset mid-evaluation discards the in-flight application; no code is issued.
- Inputs are sampled only at posedge. An application is "present" when mems != 0.
- FSM states: IDLE, EVAL, DECIDE.
  - IDLE: at edge k with application present, latch mems/lang_cer/kore_sub and go to EVAL. Otherwise stay in IDLE.
  - EVAL: at edge k+1, register score = lang_cer + 2*kore_sub (3-bit, 0..5, no overflow) and the large-family flag (mems >= 5). Go to DECIDE.
  - DECIDE: at edge k+2, load approval with the decision, update counters and quota, go to IDLE.
- approval output timing:
  - Nonzero only between edge k+2 and edge k+3; cleared to 00 at edge k+3 unconditionally.
  - Latency from sample to code = 2 edges.
  - Throughput = one application per 3 edges; the next sample is accepted at edge k+3.
- Applications present at edges where FSM is EVAL or DECIDE are ignored and increment drop_cnt.
- Decision priority, evaluated at DECIDE:
  1. Large family (mems 5..7) with kore_sub = 0 -> 10.
  2. score < MIN_SCORE -> 10.
  3. quota_used == QUOTA_MAX -> 11 (deferred); changes neither appr_cnt nor rej_cnt.
  4. Otherwise -> 01, and quota_used increments.
- Counter updates: 01 increments appr_cnt; 10 increments rej_cnt. All three counters hold at 255, no wrap.
- Quota window:
  - win_cnt is free-running 0..WINDOW_CYC-1, +1 per edge.
  - At the edge where win_cnt == WINDOW_CYC-1, win_cnt wraps to 0 and quota_used clears to 0.
  - The decision always uses quota_used as it was before the edge.
  - If an approval coincides with the wrap edge, quota_used becomes 1 (the grant counts in the new window).
- Inputs are unconstrained 2-state/4-state values. X on mems while in IDLE is a bench error, not design-handled.

Test Plan:
- Basic approve: mems=2, lang_cer=3, kore_sub=0 sampled at edge 0 after reset -> approval=01 from edge 2 to edge 3, then 00; appr_cnt=1.
- Low score: mems=1, lang_cer=0, kore_sub=1 (score 2) -> approval=10 for one cycle; rej_cnt=1, appr_cnt=0.
- Large family: mems=5, lang_cer=3, kore_sub=0 -> 10. Same with kore_sub=1 (score 5) -> 01.
- Quota/window (defaults):
  - Eligible applications at edges 0,3,6,9,12 after reset -> codes 01,01,01,01,11 at edges 2,5,8,11,14; appr_cnt=4.
  - Application at edge 15 -> 01 at edge 17 (new window); appr_cnt=5.
- Busy drop: mems=2, lang_cer=3 held constant for edges 0..5 -> decisions at edges 2 and 5 only; drop_cnt=2 (edges 1,2) plus 2 (edges 4,5) = 4.
- Reset mid-operation: application at edge 0, rst=1 at edge 1 -> approval stays 00 through edge 4; all counters 0; FSM IDLE and accepts a new application at edge 2.
